ps2_scancode_rx: RTL and testbench

PS/2 keyboard receiver that sits directly upstream of the scancode-to-matrix keyboard block. It deserialises raw PS/2 clock/data frames and strips the Set-2 E0/F0/E1 prefixes. It emits one single-cycle key event per make or break on the key_strobe/key_pressed/key_extended/key_code interface. Receive-only; the block never drives the PS/2 lines.

---
 rtl/ps2_scancode_rx.sv | 174 +++++++++++++++++
 tb/tb_ps2_scancode_rx.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: conditions raw clock/data, deserialises frames, strips Set-2 prefixes
// and emits one make/break event per key. Optional macro PS2_TYPEMATIC_FILTER_EN drops repeated makes.
module ps2_scancode_rx #(
    parameter int          FILT_LEN = 8,
    parameter logic [15:0] TIMEOUT  = 16'd50000
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       key_strobe,
    output logic       key_pressed,
    output logic       key_extended,
    output logic [7:0] key_code,
    output logic       rx_error
);
    localparam int FW = $clog2(FILT_LEN) + 1;

    typedef enum logic [2:0] {IDLE, DATA, PARITY, STOP, DECODE} state_t;
    state_t state, state_nx;

    logic [1:0]         clk_sync, data_sync;
    logic [1:0]         raw, filt;
    logic [1:0][FW-1:0] fcnt;
    logic               clk_prev, fall;
    logic               pend, pend_bit;
    logic               edge_ev, samp;
    logic [15:0]        tcnt;
    logic               active, tmo, fin;
    logic [2:0]         bcnt, skip;
    logic [7:0]         sr;
    logic               par_ok, ext, brk, is_resp, suppress;

    // Index 0 is the clock, index 1 the data line.
    assign raw = {data_sync[1], clk_sync[1]};

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            filt      <= 2'b11;
            fcnt      <= '0;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
            clk_prev  <= filt[0];
            for (int i = 0; i < 2; i++) begin
                if (raw[i] == filt[i]) begin
                    fcnt[i] <= '0;
                end else if (fcnt[i] == FW'(FILT_LEN - 1)) begin
                    filt[i] <= raw[i];
                    fcnt[i] <= '0;
                end else begin
                    fcnt[i] <= fcnt[i] + 1'b1;
                end
            end
        end
    end

    assign fall = clk_prev & ~filt[0];
    // An edge seen while in DECODE is replayed in the following IDLE cycle.
    assign edge_ev = fall | pend;
    assign samp    = pend ? pend_bit : filt[1];
    assign active  = (state == DATA) || (state == PARITY) || (state == STOP);
    assign tmo     = active && !edge_ev && (tcnt == TIMEOUT - 16'd1);
    assign fin     = (state == STOP) && edge_ev;
    assign is_resp = (sr == 8'hAA) || (sr == 8'hFA) || (sr == 8'hEE) || (sr == 8'hFE) ||
                     (sr == 8'hFC) || (sr == 8'h00) || (sr == 8'hFF);

`ifdef PS2_TYPEMATIC_FILTER_EN
    logic       held;
    logic [8:0] last_make;
    assign suppress = !brk && held && (last_make == {ext, sr});
`else
    assign suppress = 1'b0;
`endif

    always_ff @(posedge clk_sys) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (edge_ev && !samp) state_nx = DATA;
            DATA:    if (edge_ev && bcnt == 3'd7) state_nx = PARITY;
            PARITY:  if (edge_ev) state_nx = STOP;
            STOP:    if (edge_ev) state_nx = DECODE;
            DECODE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (tmo) state_nx = IDLE;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            key_strobe   <= 1'b0;
            key_pressed  <= 1'b0;
            key_extended <= 1'b0;
            key_code     <= 8'h00;
            rx_error     <= 1'b0;
            pend         <= 1'b0;
            pend_bit     <= 1'b1;
            tcnt         <= '0;
            bcnt         <= '0;
            sr           <= '0;
            par_ok       <= 1'b0;
            ext          <= 1'b0;
            brk          <= 1'b0;
            skip         <= '0;
`ifdef PS2_TYPEMATIC_FILTER_EN
            held         <= 1'b0;
            last_make    <= '0;
`endif
        end else begin
            key_strobe <= 1'b0;
            rx_error   <= 1'b0;
            pend       <= (state == DECODE) && fall;
            pend_bit   <= filt[1];

            if (!active || edge_ev || tmo) tcnt <= '0;
            else                           tcnt <= tcnt + 16'd1;

            if (state == IDLE) bcnt <= '0;
            else if (state == DATA && edge_ev) begin
                bcnt <= bcnt + 3'd1;
                sr   <= {samp, sr[7:1]};
            end

            if (state == PARITY && edge_ev) par_ok <= ^{samp, sr};

            if (tmo) begin
                rx_error <= 1'b1;
                ext      <= 1'b0;
                brk      <= 1'b0;
            end

            if (fin) begin
                if (!(par_ok && samp)) begin
                    rx_error <= 1'b1;
                    ext      <= 1'b0;
                    brk      <= 1'b0;
                end else if (skip != 3'd0) begin
                    skip <= skip - 3'd1;
                end else if (sr == 8'hE1) begin
                    skip <= 3'd7;         // rest of the Pause sequence carries no keys
                end else if (sr == 8'hE0) begin
                    ext <= 1'b1;
                end else if (sr == 8'hF0) begin
                    brk <= 1'b1;
                end else if (!is_resp) begin
                    ext <= 1'b0;
                    brk <= 1'b0;
                    if (!suppress) begin
                        key_strobe   <= 1'b1;
                        key_code     <= sr;
                        key_pressed  <= ~brk;
                        key_extended <= ext;
                    end
`ifdef PS2_TYPEMATIC_FILTER_EN
                    if (!brk) begin
                        last_make <= {ext, sr};
                        held      <= 1'b1;
                    end else if (last_make == {ext, sr}) begin
                        held      <= 1'b0;
                    end
`endif
                end
            end
        end
    end
endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Self-checking bench for ps2_scancode_rx: table of PS/2 frames with a strobe scoreboard,
// plus hand-written glitch and timeout sequences.
module tb_ps2_scancode_rx;
    logic       clk_sys = 1'b0;
    logic       reset, ps2_clk, ps2_data;
    logic       key_strobe, key_pressed, key_extended, rx_error;
    logic [7:0] key_code;

    ps2_scancode_rx dut (
        .clk_sys(clk_sys), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .key_strobe(key_strobe), .key_pressed(key_pressed), .key_extended(key_extended),
        .key_code(key_code), .rx_error(rx_error)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct { logic [7:0] code; logic pressed; logic ext; } ev_t;
    typedef struct {
        logic [7:0] data; bit bad_par; bit bad_stop; bit ev; bit pressed; bit ext; bit err;
    } vec_t;

    ev_t  exp_q[$];
    vec_t vecs[$];
    int   n_assert = 0, n_fail = 0, err_seen = 0, err_exp = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: each strobe pops the oldest expected event.
    always @(negedge clk_sys) begin
        if (!reset) begin
            if (rx_error) err_seen++;
            if (key_strobe) begin
                if (exp_q.size() == 0) begin
                    n_assert++;
                    n_fail++;
                    $display("FAIL unexpected_strobe: got code %0h pressed %0b ext %0b, expected none",
                             key_code, key_pressed, key_extended);
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    check("ev_code", {24'd0, key_code}, {24'd0, e.code});
                    check("ev_pressed", {31'd0, key_pressed}, {31'd0, e.pressed});
                    check("ev_extended", {31'd0, key_extended}, {31'd0, e.ext});
                end
            end
        end
    end

    task automatic send_bit(input logic b);
        ps2_data = b;
        repeat (20) @(negedge clk_sys);
        ps2_clk = 1'b0;
        repeat (20) @(negedge clk_sys);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop);
        logic [10:0] bits;
        bits = {~bad_stop, (~^d) ^ bad_par, d, 1'b0};
        for (int i = 0; i < 11; i++) send_bit(bits[i]);
        ps2_data = 1'b1;
        repeat (40) @(negedge clk_sys);
    endtask

    task automatic add(input logic [7:0] d, input bit bp, input bit bs, input bit ev,
                       input bit pr, input bit ex, input bit er);
        vec_t v;
        v.data = d; v.bad_par = bp; v.bad_stop = bs; v.ev = ev; v.pressed = pr; v.ext = ex; v.err = er;
        vecs.push_back(v);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        if (v.ev) exp_q.push_back('{code: v.data, pressed: v.pressed, ext: v.ext});
        if (v.err) err_exp++;
        send_frame(v.data, v.bad_par, v.bad_stop);
        check($sformatf("vec%0d_pending_events", idx), exp_q.size(), 0);
        check($sformatf("vec%0d_rx_errors", idx), err_seen, err_exp);
    endtask

    task automatic run_table();
        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);
        vecs.delete();
    endtask

    initial begin
        reset = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
        repeat (5) @(negedge clk_sys);
        check("rst_strobe", {31'd0, key_strobe}, 0);
        check("rst_code", {24'd0, key_code}, 0);
        check("rst_pressed", {31'd0, key_pressed}, 0);
        check("rst_extended", {31'd0, key_extended}, 0);
        check("rst_error", {31'd0, rx_error}, 0);
        reset = 1'b0;
        repeat (5) @(negedge clk_sys);

        //  data   bp bs ev pr ex er
        add(8'h1C, 0, 0, 1, 1, 0, 0);
        add(8'hF0, 0, 0, 0, 0, 0, 0);
        add(8'h1C, 0, 0, 1, 0, 0, 0);
        add(8'hE0, 0, 0, 0, 0, 0, 0);
        add(8'hF0, 0, 0, 0, 0, 0, 0);
        add(8'h75, 0, 0, 1, 0, 1, 0);
        add(8'h75, 0, 0, 1, 1, 0, 0);
        add(8'hF0, 0, 0, 0, 0, 0, 0);
        add(8'hE0, 0, 0, 0, 0, 0, 0);
        add(8'h75, 0, 0, 1, 0, 1, 0);
        add(8'h29, 1, 0, 0, 0, 0, 1);
        add(8'h29, 0, 0, 1, 1, 0, 0);
        add(8'hE0, 0, 0, 0, 0, 0, 0);
        add(8'h4A, 1, 0, 0, 0, 0, 1);
        add(8'h4A, 0, 0, 1, 1, 0, 0);
        add(8'h3C, 0, 1, 0, 0, 0, 1);
        add(8'hE0, 0, 0, 0, 0, 0, 0);
        add(8'hE0, 0, 0, 0, 0, 0, 0);
        add(8'h6B, 0, 0, 1, 1, 1, 0);
        add(8'hE0, 0, 0, 0, 0, 0, 0);
        add(8'hFA, 0, 0, 0, 0, 0, 0);
        add(8'h74, 0, 0, 1, 1, 1, 0);
        add(8'hE1, 0, 0, 0, 0, 0, 0);
        add(8'h14, 0, 0, 0, 0, 0, 0);
        add(8'h77, 0, 0, 0, 0, 0, 0);
        add(8'hE1, 0, 0, 0, 0, 0, 0);
        add(8'hF0, 0, 0, 0, 0, 0, 0);
        add(8'h14, 0, 0, 0, 0, 0, 0);
        add(8'hF0, 0, 0, 0, 0, 0, 0);
        add(8'h77, 0, 0, 0, 0, 0, 0);
        add(8'h16, 0, 0, 1, 1, 0, 0);
        add(8'hE0, 0, 0, 0, 0, 0, 0);
        run_table();

        // Abandoned frame after 5 data bits: timeout error, and the pending E0 is dropped.
        send_bit(1'b0);
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        ps2_data = 1'b1;
        err_exp++;
        repeat (50100) @(negedge clk_sys);
        check("timeout_error", err_seen, err_exp);
        add(8'h5A, 0, 0, 1, 1, 0, 0);
        run_table();

        // Short low glitch on the clock with data low must not start a frame.
        ps2_data = 1'b0;
        repeat (20) @(negedge clk_sys);
        ps2_clk = 1'b0;
        repeat (3) @(negedge clk_sys);
        ps2_clk = 1'b1;
        repeat (20) @(negedge clk_sys);
        ps2_data = 1'b1;
        repeat (20) @(negedge clk_sys);
        add(8'h33, 0, 0, 1, 1, 0, 0);
        run_table();

        // Typematic repeats of a held key.
        add(8'h1C, 0, 0, 1, 1, 0, 0);
`ifdef PS2_TYPEMATIC_FILTER_EN
        add(8'h1C, 0, 0, 0, 1, 0, 0);
        add(8'h1C, 0, 0, 0, 1, 0, 0);
`else
        add(8'h1C, 0, 0, 1, 1, 0, 0);
        add(8'h1C, 0, 0, 1, 1, 0, 0);
`endif
        add(8'hF0, 0, 0, 0, 0, 0, 0);
        add(8'h1C, 0, 0, 1, 0, 0, 0);
        run_table();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
